// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - execute-stage shift unit with registered output and skid buffer
//
// Purpose:
//   Computes SLL/SRL/SRA/ROR on a WIDTH-bit operand and returns the result,
//   destination tag and Zero/Neg/Carry flags one cycle after acceptance.
//   A main register drives the outputs. A second (skid) register catches one
//   op that arrives while the main register is stalled. Order is strictly FIFO.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   Flush             drop every held op and any same-cycle input
//   InValid/InReady   upstream handshake; InReady = skid register empty
//   Op, A, Shamt, Rd  op code (00 SLL, 01 SRL, 10 SRA, 11 ROR), operand, amount, tag
//   OutValid/OutReady downstream handshake to writeback
//   Result, OutRd     shifted value and its destination tag
//   Zero, Neg, Carry  Result==0, Result MSB, last bit shifted out

module shift_exec_stage #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int RDW   = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   Shamt,
  input  logic [RDW-1:0]   Rd,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic [RDW-1:0]   OutRd,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry
);

  // Packed entry layout: {result, rd, zero, neg, carry}
  localparam int PW = WIDTH + RDW + 3;

  logic [1:0] op_sll;
  logic [1:0] op_srl;
  logic [1:0] op_sra;
  assign op_sll = 2'b00;
  assign op_srl = 2'b01;
  assign op_sra = 2'b10;

  logic [WIDTH-1:0] calc_res;
  logic             calc_carry;
  logic [SHW-1:0]   s_left;
  logic [SHW-1:0]   s_m1;
  logic [PW-1:0]    calc_entry;

  // Shift datapath. WIDTH is a power of two (2**SHW), so the negated
  // amount wraps to WIDTH-s, the bit index that SLL shifts out last.
  always_comb begin
    s_left     = -Shamt;
    s_m1       = Shamt - SHW'(1);
    calc_res   = A;
    calc_carry = 1'b0;
    if (Op == op_sll) begin
      calc_res   = A << Shamt;
      calc_carry = A[s_left];
    end else if (Op == op_srl) begin
      calc_res   = A >> Shamt;
      calc_carry = A[s_m1];
    end else if (Op == op_sra) begin
      calc_res   = $signed(A) >>> Shamt;
      calc_carry = A[s_m1];
    end else begin
      calc_res   = WIDTH'({A, A} >> Shamt);
      calc_carry = A[s_m1];
    end
    // A zero amount shifts nothing out; the indices above would alias.
    if (Shamt == '0) begin
      calc_carry = 1'b0;
    end
    calc_entry = {calc_res, Rd, (calc_res == '0), calc_res[WIDTH-1], calc_carry};
  end

  logic          main_valid_q, main_valid_d;
  logic [PW-1:0] main_q, main_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          accept;
  logic          main_free;

  assign InReady   = !skid_valid_q;
  assign accept    = InValid && InReady;
  assign main_free = !main_valid_q || OutReady;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (Flush) begin
      main_valid_d = 1'b0;
      main_d       = '0;
      skid_valid_d = 1'b0;
      skid_d       = '0;
    end else if (main_free) begin
      // A full skid implies InReady=0, so no new op competes with it here.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
        skid_d       = '0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = calc_entry;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = calc_entry;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign OutValid = main_valid_q;
  assign {Result, OutRd, Zero, Neg, Carry} = main_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - scoreboard bench for shift_exec_stage

module tb_shift_exec_stage;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [1:0]  Op = 2'b00;
  logic [15:0] A = 16'h0;
  logic [3:0]  Shamt = 4'h0;
  logic [2:0]  Rd = 3'h0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [15:0] Result;
  logic [2:0]  OutRd;
  logic        Zero;
  logic        Neg;
  logic        Carry;

  int vectors = 0;
  int miscompares = 0;

  // Expected entries: {result[15:0], rd[2:0], zero, neg, carry}
  logic [21:0] sb[$];

  shift_exec_stage #(.WIDTH(16), .SHW(4), .RDW(3)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Op(Op), .A(A), .Shamt(Shamt), .Rd(Rd),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .OutRd(OutRd),
    .Zero(Zero), .Neg(Neg), .Carry(Carry)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present one op and hold it until accepted; the expected entry is queued
  // at the sampling point just before the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [3:0] s,
                      input logic [2:0] rd, input logic [15:0] er,
                      input logic ez, input logic en, input logic ec);
    bit ok;
    ok = 0;
    Op = op; A = a; Shamt = s; Rd = rd; InValid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge Clock);
      if (InReady && !Flush && !Reset) begin
        sb.push_back({er, rd, ez, en, ec});
        ok = 1;
      end
      tick();
    end
    InValid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: rd=%0d never accepted", rd);
    end
  endtask

  // Monitor: a transfer happens on the edge after a negedge that sees
  // OutValid & OutReady with no Flush/Reset pending.
  initial begin
    logic [21:0] exp;
    forever begin
      @(negedge Clock);
      if (!Reset && !Flush && OutValid && OutReady) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: res=%h rd=%0d with empty scoreboard", Result, OutRd);
        end else begin
          exp = sb.pop_front();
          if ({Result, OutRd, Zero, Neg, Carry} !== exp) begin
            miscompares++;
            $display("FAIL result: got res=%h rd=%0d z=%b n=%b c=%b, want res=%h rd=%0d z=%b n=%b c=%b",
                     Result, OutRd, Zero, Neg, Carry,
                     exp[21:6], exp[5:3], exp[2], exp[1], exp[0]);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    @(negedge Clock);
    chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_result", {16'b0, Result}, 32'd0);
    chk("rst_outrd", {29'b0, OutRd}, 32'd0);
    chk("rst_flags", {29'b0, Zero, Neg, Carry}, 32'd0);
    chk("rst_inready", {31'b0, InReady}, 32'd1);
    tick();
    Reset = 1'b0;

    // Full-throughput stream of hand-computed vectors
    OutReady = 1'b1;
    send(2'b10, 16'h8000, 4'd3,  3'd0, 16'hF000, 1'b0, 1'b1, 1'b0);
    send(2'b00, 16'hC000, 4'd1,  3'd1, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(2'b01, 16'h8001, 4'd1,  3'd2, 16'h4000, 1'b0, 1'b0, 1'b1);
    send(2'b11, 16'h1234, 4'd4,  3'd3, 16'h4123, 1'b0, 1'b0, 1'b0);
    send(2'b10, 16'h7FFF, 4'd15, 3'd4, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(2'b00, 16'h1234, 4'd0,  3'd5, 16'h1234, 1'b0, 1'b0, 1'b0);
    send(2'b11, 16'h8001, 4'd1,  3'd6, 16'hC000, 1'b0, 1'b1, 1'b1);
    send(2'b01, 16'hFFFF, 4'd15, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(2'b00, 16'h0001, 4'd15, 3'd0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(2'b10, 16'hFFFF, 4'd0,  3'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    tick();
    tick();

    // Backpressure: Rd=1 to main, Rd=2 to skid, Rd=3 held upstream
    OutReady = 1'b0;
    send(2'b00, 16'h0003, 4'd2, 3'd1, 16'h000C, 1'b0, 1'b0, 1'b0);
    send(2'b01, 16'h00F0, 4'd4, 3'd2, 16'h000F, 1'b0, 1'b0, 1'b0);
    Op = 2'b11; A = 16'h0001; Shamt = 4'd1; Rd = 3'd3; InValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("bp_inready", {31'b0, InReady}, 32'd0);
      chk("bp_hold_rd", {29'b0, OutRd}, 32'd1);
      chk("bp_hold_res", {16'b0, Result}, 32'h000C);
      tick();
    end
    OutReady = 1'b1;
    send(2'b11, 16'h0001, 4'd1, 3'd3, 16'h8000, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    chk("bp_drained", sb.size(), 32'd0);

    // Flush with both registers full and an input presented
    OutReady = 1'b0;
    send(2'b10, 16'hF000, 4'd4, 3'd4, 16'hFF00, 1'b0, 1'b1, 1'b0);
    send(2'b00, 16'h00FF, 4'd8, 3'd5, 16'hFF00, 1'b0, 1'b1, 1'b0);
    Op = 2'b00; A = 16'h1111; Shamt = 4'd1; Rd = 3'd6; InValid = 1'b1; Flush = 1'b1;
    sb.delete();
    tick();
    Flush = 1'b0;
    InValid = 1'b0;
    @(negedge Clock);
    chk("flush_outvalid", {31'b0, OutValid}, 32'd0);
    chk("flush_inready", {31'b0, InReady}, 32'd1);
    tick();
    @(negedge Clock);
    chk("flush_dropped", {31'b0, OutValid}, 32'd0);

    // Flush beats accept when the stage is ready
    tick();
    OutReady = 1'b1;
    InValid = 1'b1; Flush = 1'b1;
    tick();
    InValid = 1'b0; Flush = 1'b0;
    @(negedge Clock);
    chk("flush_beats_accept", {31'b0, OutValid}, 32'd0);
    tick();

    // Reset while holding a result, then 1-cycle latency recovery
    OutReady = 1'b0;
    send(2'b10, 16'h8000, 4'd1, 3'd7, 16'hC000, 1'b0, 1'b1, 1'b0);
    @(negedge Clock);
    chk("pre_rst_outvalid", {31'b0, OutValid}, 32'd1);
    tick();
    Reset = 1'b1;
    sb.delete();
    tick();
    Reset = 1'b0;
    @(negedge Clock);
    chk("mid_rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("mid_rst_result", {16'b0, Result}, 32'd0);
    chk("mid_rst_outrd", {29'b0, OutRd}, 32'd0);
    chk("mid_rst_flags", {29'b0, Zero, Neg, Carry}, 32'd0);
    chk("mid_rst_inready", {31'b0, InReady}, 32'd1);
    tick();
    OutReady = 1'b1;
    send(2'b01, 16'h0F00, 4'd8, 3'd2, 16'h000F, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    chk("post_rst_latency", {31'b0, OutValid}, 32'd1);
    tick();

    // Drain and verify nothing is left outstanding
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      tick();
    end
    tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
